// File: rtl/rgb_pwm_pkg.sv
// +----------------------------------------------------------------------------+
// | rgb_pwm_pkg                                                                |
// | Shared types, constants and helpers for the rgb_pwm_bank slice.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package rgb_pwm_pkg;

  localparam int PWM_WIDTH_DEF = 12;
  localparam int PWM_PERIOD    = (1 << PWM_WIDTH_DEF) - 1;

  typedef logic [PWM_WIDTH_DEF-1:0] duty_t;

  // Commit FSM encoding
  localparam logic [0:0] c_st_idle    = 1'b0;
  localparam logic [0:0] c_st_pending = 1'b1;

  // Width of a channel index; never below one bit so the port always exists
  function automatic int chan_idx_w(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rgb_pwm_bank_timebase.sv
// +----------------------------------------------------------------------------+
// | pwm_timebase                                                               |
// | Prescaler plus PWM counter; flags the period wrap and a period_start pulse.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module pwm_timebase #(
  parameter int PWM_WIDTH = 12,
  parameter int PRESCALE  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic [PWM_WIDTH-1:0] o_cnt,
  output logic                 o_wrap,
  output logic                 o_period_start
);

  localparam int c_pw = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [c_pw-1:0]      c_presc_last = c_pw'(PRESCALE - 1);
  localparam logic [PWM_WIDTH-1:0] c_cnt_last   = PWM_WIDTH'((1 << PWM_WIDTH) - 2);

  logic [c_pw-1:0]      r_presc;
  logic [PWM_WIDTH-1:0] r_cnt;
  logic                 r_period_start;
  logic                 w_tick;
  logic                 w_wrap;

  assign w_tick = (r_presc == c_presc_last);
  // The counter skips the all-ones value so a full-scale duty stays on
  assign w_wrap = w_tick && (r_cnt == c_cnt_last);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_presc        <= '0;
      r_cnt          <= '0;
      r_period_start <= 1'b0;
    end else begin
      r_presc        <= w_tick ? '0 : r_presc + c_pw'(1);
      if (w_tick) begin
        r_cnt <= w_wrap ? '0 : r_cnt + PWM_WIDTH'(1);
      end
      r_period_start <= w_wrap;
    end
  end

  assign o_cnt          = r_cnt;
  assign o_wrap         = w_wrap;
  assign o_period_start = r_period_start;

endmodule

`default_nettype wire

// File: rtl/rgb_pwm_bank.sv
// +----------------------------------------------------------------------------+
// | rgb_pwm_bank                                                               |
// | Multi-channel PWM with shadow duties committed only at period boundaries.  |
// | Optional global dimming at transfer: define PWM_GLOBAL_DIM_EN.             |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module rgb_pwm_bank
  import rgb_pwm_pkg::*;
#(
  parameter int PWM_WIDTH = 12,
  parameter int CHANNELS  = 3,
  parameter int PRESCALE  = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_valid,
  input  logic [chan_idx_w(CHANNELS)-1:0]   wr_chan,
  input  logic [PWM_WIDTH-1:0]              wr_duty,
  input  logic                              commit_valid,
  output logic                              commit_ready,
`ifdef PWM_GLOBAL_DIM_EN
  input  logic [PWM_WIDTH-1:0]              dim,
`endif
  output logic                              period_start,
  output logic [CHANNELS-1:0]               led
);

  localparam int c_cw = chan_idx_w(CHANNELS);
`ifdef PWM_GLOBAL_DIM_EN
  localparam int c_pw = 2 * PWM_WIDTH + 1;
`endif

  logic [PWM_WIDTH-1:0] w_cnt;
  logic                 w_wrap;
  logic [PWM_WIDTH-1:0] r_shadow [CHANNELS];
  logic [PWM_WIDTH-1:0] r_active [CHANNELS];
  logic [PWM_WIDTH-1:0] w_load   [CHANNELS];
  logic [0:0]           r_state;
  logic [0:0]           w_state_next;
  logic                 w_xfer;

  pwm_timebase #(
    .PWM_WIDTH (PWM_WIDTH),
    .PRESCALE  (PRESCALE)
  ) u_timebase (
    .clk            (clk),
    .rst_n          (rst_n),
    .o_cnt          (w_cnt),
    .o_wrap         (w_wrap),
    .o_period_start (period_start)
  );

  // Out-of-range indices match no channel and are dropped
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_shadow[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (wr_valid && (wr_chan == c_cw'(i))) r_shadow[i] <= wr_duty;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
`ifdef PWM_GLOBAL_DIM_EN
      w_load[i] = PWM_WIDTH'((c_pw'(r_shadow[i]) * (c_pw'(dim) + c_pw'(1))) >> PWM_WIDTH);
`else
      w_load[i] = r_shadow[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++) r_active[i] <= '0;
    end else if (w_xfer) begin
      for (int i = 0; i < CHANNELS; i++) r_active[i] <= w_load[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= c_st_idle;
    else        r_state <= w_state_next;
  end

  // A commit taken on the wrap cycle itself is still idle at that wrap, so it waits a period
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_idle:    if (commit_valid) w_state_next = c_st_pending;
      c_st_pending: if (w_wrap)       w_state_next = c_st_idle;
      default:                        w_state_next = c_st_idle;
    endcase
  end

  always_comb begin
    commit_ready = (r_state == c_st_idle);
    w_xfer       = (r_state == c_st_pending) && w_wrap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) led[i] <= (r_active[i] > w_cnt);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rgb_pwm_bank.sv
// +----------------------------------------------------------------------------+
// | tb_rgb_pwm_bank                                                            |
// | Self-checking bench: 4-bit PWM, PRESCALE 1 and 3 instances.                |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_rgb_pwm_bank;

  localparam int W  = 4;
  localparam int CH = 3;
  localparam int P  = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_valid, commit_valid, commit_ready, period_start;
  logic [1:0] wr_chan;
  logic [3:0] wr_duty;
  logic [2:0] led;
  logic       b_wr_valid, b_commit_valid, b_commit_ready, b_period_start;
  logic [1:0] b_wr_chan;
  logic [3:0] b_wr_duty;
  logic [2:0] b_led;
`ifdef PWM_GLOBAL_DIM_EN
  logic [3:0] dim;
  logic [3:0] b_dim;
`endif

  int checks = 0;
  int errors = 0;
  int sh   [CH];
  int act  [CH];
  int hcnt [CH];

  always #5 clk = ~clk;

  rgb_pwm_bank #(.PWM_WIDTH(W), .CHANNELS(CH), .PRESCALE(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_chan(wr_chan), .wr_duty(wr_duty),
    .commit_valid(commit_valid), .commit_ready(commit_ready),
`ifdef PWM_GLOBAL_DIM_EN
    .dim(dim),
`endif
    .period_start(period_start), .led(led)
  );

  rgb_pwm_bank #(.PWM_WIDTH(W), .CHANNELS(CH), .PRESCALE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .wr_valid(b_wr_valid), .wr_chan(b_wr_chan), .wr_duty(b_wr_duty),
    .commit_valid(b_commit_valid), .commit_ready(b_commit_ready),
`ifdef PWM_GLOBAL_DIM_EN
    .dim(b_dim),
`endif
    .period_start(b_period_start), .led(b_led)
  );

  task automatic wait_ps;
    int n = 0;
    do begin @(negedge clk); n++; end while (!period_start && n < 200);
    checks++;
    if (!period_start) begin
      errors++;
      $display("FAIL wait_ps: period_start=%b after %0d clks, required 1", period_start, n);
    end
  endtask

  task automatic write_a(input int ch, input int d);
    wr_valid = 1'b1; wr_chan = 2'(ch); wr_duty = 4'(d);
    @(negedge clk);
    wr_valid = 1'b0;
    if (ch < CH) sh[ch] = d;
  endtask

  task automatic commit_a;
    commit_valid = 1'b1;
    @(negedge clk);
    commit_valid = 1'b0;
  endtask

  // Duty a channel should run with once the shadow set is transferred
  task automatic apply_transfer;
    for (int c = 0; c < CH; c++) begin
`ifdef PWM_GLOBAL_DIM_EN
      act[c] = (sh[c] * (int'(dim) + 1)) / 16;
`else
      act[c] = sh[c];
`endif
    end
  endtask

  // Called on a period_start sample; counts on-cycles across the next full period
  task automatic measure_a;
    for (int c = 0; c < CH; c++) hcnt[c] = 0;
    repeat (P) begin
      @(negedge clk);
      for (int c = 0; c < CH; c++) if (led[c]) hcnt[c]++;
    end
  endtask

  task automatic test_reset;
    int n;
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (led !== 3'b000 || commit_ready !== 1'b1 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: led=%b ready=%b ps=%b, required 000 1 0", led, commit_ready, period_start);
    end
    rst_n = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!period_start && n < 200);
    checks++;
    if (n != P) begin
      errors++;
      $display("FAIL reset_first_period: %0d clks, required %0d", n, P);
    end
    write_a(0, 9);
    commit_a();
    rst_n = 1'b0;
    repeat (4) @(negedge clk);
    for (int c = 0; c < CH; c++) begin sh[c] = 0; act[c] = 0; end
    checks++;
    if (led !== 3'b000 || commit_ready !== 1'b1 || period_start !== 1'b0) begin
      errors++;
      $display("FAIL reset_midrun: led=%b ready=%b ps=%b, required 000 1 0", led, commit_ready, period_start);
    end
    rst_n = 1'b1;
    wait_ps();
    measure_a();
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (hcnt[c] != 0) begin
        errors++;
        $display("FAIL reset_abort_commit ch%0d: high %0d clks, required 0", c, hcnt[c]);
      end
    end
  endtask

  task automatic test_duty_random;
    int d [CH];
    for (int r = 0; r < 6; r++) begin
      for (int c = 0; c < CH; c++) d[c] = $urandom_range(0, 15);
      if (r == 0) begin d[0] = 5; d[1] = 0; d[2] = 15; end
      for (int c = 0; c < CH; c++) write_a(c, d[c]);
      commit_a();
      wait_ps();
      apply_transfer();
      checks++;
      if (commit_ready !== 1'b1) begin
        errors++;
        $display("FAIL duty_ready r%0d: ready=%b, required 1", r, commit_ready);
      end
      measure_a();
      for (int c = 0; c < CH; c++) begin
        checks++;
        if (hcnt[c] != act[c]) begin
          errors++;
          $display("FAIL duty r%0d ch%0d: high %0d of 15, required %0d", r, c, hcnt[c], act[c]);
        end
      end
    end
  endtask

  task automatic test_glitch;
    int p;
    int old_d;
    write_a(1, 7);
    commit_a();
    wait_ps();
    apply_transfer();
    old_d = act[1];
    p = 0;
    write_a(1, 10); p++;
    repeat (2) begin @(negedge clk); p++; end
    commit_a(); p++;
    write_a(1, 2); p++;
    while (p < P) begin
      @(negedge clk); p++;
      checks++;
      if (led[1] !== ((old_d > p - 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL glitch_hold cnt=%0d: led1=%b, required %b", p - 1, led[1], old_d > p - 1);
      end
    end
    checks++;
    if (period_start !== 1'b1) begin
      errors++;
      $display("FAIL glitch_wrap: period_start=%b, required 1", period_start);
    end
    apply_transfer();
    measure_a();
    checks++;
    if (hcnt[1] != act[1]) begin
      errors++;
      $display("FAIL glitch_new ch1: high %0d, required %0d", hcnt[1], act[1]);
    end
  endtask

  task automatic test_handshake;
    int first_ready;
    int hi0;
    int prev0;
    write_a(2, (sh[2] + 1 + $urandom_range(0, 13)) % 16);
    commit_a();
    checks++;
    if (commit_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_pending: ready=%b, required 0", commit_ready);
    end
    commit_a();
    checks++;
    if (commit_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_second: ready=%b, required 0", commit_ready);
    end
    wait_ps();
    apply_transfer();
    measure_a();
    checks++;
    if (hcnt[2] != act[2]) begin
      errors++;
      $display("FAIL hs_xfer ch2: high %0d, required %0d", hcnt[2], act[2]);
    end
    // Commit lands exactly on the wrap cycle
    prev0 = act[0];
    write_a(0, (sh[0] + 1 + $urandom_range(0, 13)) % 16);
    repeat (13) @(negedge clk);
    commit_a();
    checks++;
    if (period_start !== 1'b1 || commit_ready !== 1'b0) begin
      errors++;
      $display("FAIL hs_wrap_commit: ps=%b ready=%b, required 1 0", period_start, commit_ready);
    end
    first_ready = -1;
    hi0 = 0;
    for (int k = 1; k <= P; k++) begin
      @(negedge clk);
      if (led[0]) hi0++;
      if (commit_ready === 1'b1 && first_ready < 0) first_ready = k;
    end
    checks++;
    if (first_ready != P) begin
      errors++;
      $display("FAIL hs_deferred: ready after %0d clks, required %0d", first_ready, P);
    end
    checks++;
    if (hi0 != prev0) begin
      errors++;
      $display("FAIL hs_deferred_old ch0: high %0d, required %0d", hi0, prev0);
    end
    apply_transfer();
    measure_a();
    checks++;
    if (hcnt[0] != act[0]) begin
      errors++;
      $display("FAIL hs_deferred_new ch0: high %0d, required %0d", hcnt[0], act[0]);
    end
  endtask

  task automatic test_out_of_range;
    write_a(3, 15);
    commit_a();
    wait_ps();
    apply_transfer();
    measure_a();
    for (int c = 0; c < CH; c++) begin
      checks++;
      if (hcnt[c] != act[c]) begin
        errors++;
        $display("FAIL oor ch%0d: high %0d, required %0d", c, hcnt[c], act[c]);
      end
    end
  endtask

`ifdef PWM_GLOBAL_DIM_EN
  task automatic test_dim;
    int dv [3];
    int exp_v;
    dv[0] = 7; dv[1] = 15; dv[2] = 0;
    for (int t = 0; t < 3; t++) begin
      dim = 4'(dv[t]);
      for (int c = 0; c < CH; c++) write_a(c, 15);
      commit_a();
      wait_ps();
      apply_transfer();
      exp_v = (15 * (dv[t] + 1)) / 16;
      measure_a();
      checks++;
      if (hcnt[0] != exp_v || act[0] != exp_v) begin
        errors++;
        $display("FAIL dim=%0d: high %0d, required %0d", dv[t], hcnt[0], exp_v);
      end
    end
    dim = 4'hF;
  endtask
`endif

  task automatic test_prescale;
    int n;
    int hb [CH];
    int to;
    to = 0;
    while (!b_period_start && to < 500) begin @(negedge clk); to++; end
    b_wr_valid = 1'b1;
    b_wr_chan = 2'd0; b_wr_duty = 4'd5;  @(negedge clk);
    b_wr_chan = 2'd2; b_wr_duty = 4'd12; @(negedge clk);
    b_wr_chan = 2'd3; b_wr_duty = 4'd15; @(negedge clk);
    b_wr_valid = 1'b0;
    b_commit_valid = 1'b1; @(negedge clk); b_commit_valid = 1'b0;
    to = 0;
    do begin @(negedge clk); to++; end while (!b_period_start && to < 500);
    for (int c = 0; c < CH; c++) hb[c] = 0;
    n = 0;
    do begin
      @(negedge clk); n++;
      for (int c = 0; c < CH; c++) if (b_led[c]) hb[c]++;
    end while (!b_period_start && n < 500);
    checks++;
    if (n != 3 * P) begin
      errors++;
      $display("FAIL prescale_period: %0d clks, required %0d", n, 3 * P);
    end
    checks++;
`ifdef PWM_GLOBAL_DIM_EN
    if (hb[0] != 3 * ((5 * (int'(b_dim) + 1)) / 16) || hb[1] != 0 || hb[2] != 3 * ((12 * (int'(b_dim) + 1)) / 16)) begin
`else
    if (hb[0] != 15 || hb[1] != 0 || hb[2] != 36) begin
`endif
      errors++;
      $display("FAIL prescale_duty: high %0d/%0d/%0d, required 15/0/36", hb[0], hb[1], hb[2]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_chan = '0; wr_duty = '0; commit_valid = 1'b0;
    b_wr_valid = 1'b0; b_wr_chan = '0; b_wr_duty = '0; b_commit_valid = 1'b0;
`ifdef PWM_GLOBAL_DIM_EN
    dim = 4'hF; b_dim = 4'hF;
`endif
    for (int c = 0; c < CH; c++) begin sh[c] = 0; act[c] = 0; end
    test_reset();
    test_duty_random();
    test_glitch();
    test_handshake();
    test_out_of_range();
`ifdef PWM_GLOBAL_DIM_EN
    test_dim();
`endif
    test_prescale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
